// File: rtl/riscv_bif_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : riscv_bif_arbiter
// Purpose  : Shares the external bif between the instruction-fetch port (I)
//            and the EX-stage data port (D). Locks the grant until the bus
//            accepts it, and routes read returns back to their issuer through
//            an in-order source-ID FIFO.
// Options  : RISCV_BIF_ARB_RR_EN - round-robin tie break between I and D.
//            Undefined (default): fixed priority, D wins every tie.
// Revision : 1.0 - initial release
// ============================================================================
module riscv_bif_arbiter #(
   parameter int OUTST_DEPTH = 4,
   parameter int OUTST_PTR_W = 2
) (
   input  logic        clk,
   input  logic        rstn,
   // instruction-fetch requester (read-only)
   input  logic        i_bif_req,
   input  logic [31:0] i_bif_addr,
   output logic        i_bif_ack,
   output logic [31:0] i_bif_rdata,
   output logic        i_bif_rvalid,
   // data requester (read/write)
   input  logic        d_bif_req,
   input  logic        d_bif_rnw,
   input  logic [31:0] d_bif_addr,
   input  logic [3:0]  d_bif_wmask,
   input  logic [31:0] d_bif_wdata,
   output logic        d_bif_ack,
   output logic [31:0] d_bif_rdata,
   output logic        d_bif_rvalid,
   // memory-side bus
   output logic        m_bif_req,
   output logic        m_bif_rnw,
   output logic [31:0] m_bif_addr,
   output logic [3:0]  m_bif_wmask,
   output logic [31:0] m_bif_wdata,
   input  logic        m_bif_ack,
   input  logic [31:0] m_bif_rdata,
   input  logic        m_bif_rvalid,
   output logic        err_rvalid
);

   localparam logic                 c_SRC_I    = 1'b0;
   localparam logic                 c_SRC_D    = 1'b1;
   localparam logic [OUTST_PTR_W:0] c_FULL_CNT = (OUTST_PTR_W + 1)'(OUTST_DEPTH);

   typedef enum logic [0:0] {
      ST_UNLOCKED = 1'b0,
      ST_LOCKED   = 1'b1
   } lock_state_t;

   lock_state_t            r_state;
   lock_state_t            w_state_nxt;
   logic                   r_owner;
   logic                   w_owner_nxt;
   logic [OUTST_DEPTH-1:0] r_fifo;
   logic [OUTST_PTR_W-1:0] r_wr_ptr;
   logic [OUTST_PTR_W-1:0] r_rd_ptr;
   logic [OUTST_PTR_W:0]   r_cnt;
   logic                   r_err;

   logic w_full;
   logic w_empty;
   logic w_i_elig;
   logic w_d_elig;
   logic w_prio;
   logic w_gnt_valid;
   logic w_gnt_src;
   logic w_accept;
   logic w_push;
   logic w_pop;
   logic w_head;

   // Full is judged on the registered count, so a same-cycle pop never frees a slot early
   assign w_full   = (r_cnt == c_FULL_CNT);
   assign w_empty  = (r_cnt == '0);
   assign w_head   = r_fifo[r_rd_ptr];
   assign w_i_elig = i_bif_req && !w_full;
   assign w_d_elig = d_bif_req && (!d_bif_rnw || !w_full);

`ifdef RISCV_BIF_ARB_RR_EN
   logic r_prio;

   // Tie-break pointer: after every accept the requester that did not win gets priority
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_prio <= c_SRC_D;
      end else if (w_accept) begin
         r_prio <= ~w_gnt_src;
      end
   end

   assign w_prio = r_prio;
`else
   assign w_prio = c_SRC_D;
`endif

   // Grant selection and lock next-state: a held grant ignores the other requester
   always_comb begin
      w_gnt_valid = 1'b0;
      w_gnt_src   = c_SRC_D;
      w_state_nxt = r_state;
      w_owner_nxt = r_owner;
      if (!rstn) begin
         w_gnt_valid = 1'b0;
      end else if (r_state == ST_LOCKED) begin
         // A requester that drops req while locked simply presents no request
         w_gnt_src   = r_owner;
         w_gnt_valid = (r_owner == c_SRC_D) ? d_bif_req : i_bif_req;
      end else if (w_i_elig && w_d_elig) begin
         w_gnt_valid = 1'b1;
         w_gnt_src   = w_prio;
      end else if (w_d_elig) begin
         w_gnt_valid = 1'b1;
         w_gnt_src   = c_SRC_D;
      end else if (w_i_elig) begin
         w_gnt_valid = 1'b1;
         w_gnt_src   = c_SRC_I;
      end
      case (r_state)
         ST_UNLOCKED: begin
            if (w_gnt_valid && !m_bif_ack) begin
               w_state_nxt = ST_LOCKED;
               w_owner_nxt = w_gnt_src;
            end
         end
         ST_LOCKED: begin
            if (w_gnt_valid && m_bif_ack) begin
               w_state_nxt = ST_UNLOCKED;
            end
         end
         default: w_state_nxt = ST_UNLOCKED;
      endcase
   end

   // Lock state register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= ST_UNLOCKED;
         r_owner <= c_SRC_I;
      end else begin
         r_state <= w_state_nxt;
         r_owner <= w_owner_nxt;
      end
   end

   // Bus field mux from the granted requester; fetch is always a full-word read
   always_comb begin
      m_bif_req   = 1'b0;
      m_bif_rnw   = 1'b0;
      m_bif_addr  = '0;
      m_bif_wmask = '0;
      m_bif_wdata = '0;
      if (w_gnt_valid) begin
         m_bif_req = 1'b1;
         if (w_gnt_src == c_SRC_D) begin
            m_bif_rnw   = d_bif_rnw;
            m_bif_addr  = d_bif_addr;
            m_bif_wmask = d_bif_rnw ? 4'h0 : d_bif_wmask;
            m_bif_wdata = d_bif_wdata;
         end else begin
            m_bif_rnw  = 1'b1;
            m_bif_addr = i_bif_addr;
         end
      end
   end

   assign w_accept = w_gnt_valid && m_bif_ack;
   assign i_bif_ack = w_accept && (w_gnt_src == c_SRC_I);
   assign d_bif_ack = w_accept && (w_gnt_src == c_SRC_D);
   assign w_push    = w_accept && m_bif_rnw;
   assign w_pop     = m_bif_rvalid && !w_empty;

   // Returns are in acceptance order, so the FIFO head names the owner of this rdata
   assign i_bif_rvalid = w_pop && (w_head == c_SRC_I);
   assign d_bif_rvalid = w_pop && (w_head == c_SRC_D);
   assign i_bif_rdata  = rstn ? m_bif_rdata : 32'h0;
   assign d_bif_rdata  = rstn ? m_bif_rdata : 32'h0;
   assign err_rvalid   = r_err;

   // Source-ID FIFO bookkeeping and sticky unexpected-return flag
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_fifo   <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_cnt    <= '0;
         r_err    <= 1'b0;
      end else begin
         if (w_push) begin
            r_fifo[r_wr_ptr] <= w_gnt_src;
            r_wr_ptr         <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         if (w_push && !w_pop) begin
            r_cnt <= r_cnt + 1'b1;
         end else if (!w_push && w_pop) begin
            r_cnt <= r_cnt - 1'b1;
         end
         if (m_bif_rvalid && w_empty) begin
            r_err <= 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_riscv_bif_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_riscv_bif_arbiter
// Purpose  : Self-checking bench for riscv_bif_arbiter: vector table, directed
//            corner-case sequences and constrained-random traffic compared
//            against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_bif_arbiter;

   localparam int DEPTH = 4;
`ifdef RISCV_BIF_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        i_req, d_req, d_rnw, m_ack, m_rvalid;
   logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
   logic [3:0]  d_wmask;
   logic        i_bif_ack, i_bif_rvalid, d_bif_ack, d_bif_rvalid;
   logic [31:0] i_bif_rdata, d_bif_rdata;
   logic        m_bif_req, m_bif_rnw, err_rvalid;
   logic [31:0] m_bif_addr, m_bif_wdata;
   logic [3:0]  m_bif_wmask;

   always #5 clk = ~clk;

   riscv_bif_arbiter #(.OUTST_DEPTH(DEPTH), .OUTST_PTR_W(2)) u_dut (
      .clk          (clk),
      .rstn         (rstn),
      .i_bif_req    (i_req),
      .i_bif_addr   (i_addr),
      .i_bif_ack    (i_bif_ack),
      .i_bif_rdata  (i_bif_rdata),
      .i_bif_rvalid (i_bif_rvalid),
      .d_bif_req    (d_req),
      .d_bif_rnw    (d_rnw),
      .d_bif_addr   (d_addr),
      .d_bif_wmask  (d_wmask),
      .d_bif_wdata  (d_wdata),
      .d_bif_ack    (d_bif_ack),
      .d_bif_rdata  (d_bif_rdata),
      .d_bif_rvalid (d_bif_rvalid),
      .m_bif_req    (m_bif_req),
      .m_bif_rnw    (m_bif_rnw),
      .m_bif_addr   (m_bif_addr),
      .m_bif_wmask  (m_bif_wmask),
      .m_bif_wdata  (m_bif_wdata),
      .m_bif_ack    (m_ack),
      .m_bif_rdata  (m_rdata),
      .m_bif_rvalid (m_rvalid),
      .err_rvalid   (err_rvalid)
   );

   // ---------------- reference model (transaction level) ----------------
   bit mq[$];        // source IDs of reads accepted but not yet returned (1 = D)
   bit m_locked, m_owner, m_prio, m_err;
   logic        e_req, e_rnw, e_src, e_iack, e_dack, e_irv, e_drv;
   logic [31:0] e_addr, e_wdata;
   logic [3:0]  e_wmask;

   int checks = 0;
   int failures = 0;

   typedef struct packed {
      logic        i_req;
      logic [31:0] i_addr;
      logic        d_req;
      logic        d_rnw;
      logic [31:0] d_addr;
      logic [3:0]  d_wmask;
      logic [31:0] d_wdata;
      logic        m_ack;
      logic [71:0] exp;   // {req, rnw, addr, wmask, wdata, i_ack, d_ack}
   } vec_t;
   vec_t vecs[7];

   task automatic model_reset();
      mq.delete();
      m_locked = 1'b0;
      m_owner  = 1'b0;
      m_prio   = 1'b1;
      m_err    = 1'b0;
   endtask

   task automatic model_eval();
      bit full, ie, de, gv, src;
      full = (mq.size() >= DEPTH);
      gv = 1'b0;
      src = 1'b1;
      if (m_locked) begin
         src = m_owner;
         gv  = src ? d_req : i_req;
      end else begin
         ie = i_req && !full;
         de = d_req && (!d_rnw || !full);
         if (ie && de) begin gv = 1'b1; src = RR ? m_prio : 1'b1; end
         else if (de)  begin gv = 1'b1; src = 1'b1; end
         else if (ie)  begin gv = 1'b1; src = 1'b0; end
      end
      if (!rstn) gv = 1'b0;
      e_req   = gv;
      e_src   = src;
      e_rnw   = gv && (src ? d_rnw : 1'b1);
      e_addr  = !gv ? 32'h0 : (src ? d_addr : i_addr);
      e_wmask = (gv && src && !d_rnw) ? d_wmask : 4'h0;
      e_wdata = (gv && src) ? d_wdata : 32'h0;
      e_iack  = gv && m_ack && !src;
      e_dack  = gv && m_ack && src;
      e_irv   = 1'b0;
      e_drv   = 1'b0;
      if (rstn && m_rvalid && mq.size() > 0) begin
         e_irv = (mq[0] == 1'b0);
         e_drv = (mq[0] == 1'b1);
      end
   endtask

   task automatic model_update();
      bit acc;
      if (!rstn) begin
         model_reset();
         return;
      end
      acc = e_req && m_ack;
      if (m_rvalid) begin
         if (mq.size() == 0) m_err = 1'b1;
         else void'(mq.pop_front());
      end
      if (acc && e_rnw) mq.push_back(e_src);
      if (!m_locked && e_req && !m_ack) begin
         m_locked = 1'b1;
         m_owner  = e_src;
      end else if (m_locked && acc) begin
         m_locked = 1'b0;
      end
      if (acc) m_prio = !e_src;
   endtask

   function automatic logic [138:0] dut_outs();
      return {m_bif_req, m_bif_rnw, m_bif_addr, m_bif_wmask, m_bif_wdata, i_bif_ack, d_bif_ack,
              i_bif_rvalid, d_bif_rvalid, i_bif_rdata, d_bif_rdata, err_rvalid};
   endfunction

   task automatic chk(input string name, input logic [159:0] act, input logic [159:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s @%0t actual=%h required=%h", name, $time, act, req);
      end
   endtask

   task automatic compare_model();
      logic [31:0] rd;
      rd = rstn ? m_rdata : 32'h0;
      chk("model", 160'(dut_outs()),
          160'({e_req, e_rnw, e_addr, e_wmask, e_wdata, e_iack, e_dack, e_irv, e_drv, rd, rd, m_err}));
   endtask

   task automatic cyc_check();
      @(negedge clk);
      model_eval();
      compare_model();
   endtask

   task automatic cyc_adv();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic step();
      cyc_check();
      cyc_adv();
   endtask

   task automatic idle();
      i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_rnw = 1'b0; d_addr = '0;
      d_wmask = '0; d_wdata = '0; m_ack = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
   endtask

   task automatic do_reset();
      idle();
      rstn = 1'b0;
      model_reset();
      step();
      step();
      rstn = 1'b1;
   endtask

   task automatic drain();
      while (mq.size() > 0) begin
         idle();
         m_rvalid = 1'b1;
         m_rdata  = $urandom();
         step();
      end
      idle();
   endtask

   task automatic rand_run(input int n);
      for (int c = 0; c < n; c++) begin
         if (!i_req || e_iack) begin
            i_req  = 1'($urandom_range(0, 1));
            i_addr = $urandom() & 32'hFFFF_FFFC;
         end
         if (!d_req || e_dack) begin
            d_req   = 1'($urandom_range(0, 1));
            d_rnw   = 1'($urandom_range(0, 1));
            d_addr  = $urandom();
            d_wmask = 4'($urandom());
            d_wdata = d_rnw ? 32'h0 : $urandom();
         end
         m_ack    = ($urandom_range(0, 3) != 0);
         m_rvalid = (mq.size() > 0) && ($urandom_range(0, 1) == 1);
         m_rdata  = $urandom();
         step();
      end
      idle();
   endtask

   initial begin
      idle();
      model_reset();

      // single-cycle vectors from an idle, unlocked, empty state
      vecs[0] = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   4'h0, 32'h0,        1'b1,
                  {1'b0, 1'b0, 32'h0,   4'h0, 32'h0,        1'b0, 1'b0}};
      vecs[1] = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h0,   4'h0, 32'h0,        1'b1,
                  {1'b1, 1'b1, 32'h100, 4'h0, 32'h0,        1'b1, 1'b0}};
      vecs[2] = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h200, 4'hF, 32'hDEADBEEF, 1'b1,
                  {1'b1, 1'b0, 32'h200, 4'hF, 32'hDEADBEEF, 1'b0, 1'b1}};
      vecs[3] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h300, 4'h5, 32'h0,        1'b0,
                  {1'b1, 1'b1, 32'h300, 4'h0, 32'h0,        1'b0, 1'b0}};
      vecs[4] = '{1'b1, 32'h100, 1'b1, 1'b0, 32'h200, 4'hF, 32'hDEADBEEF, 1'b1,
                  {1'b1, 1'b0, 32'h200, 4'hF, 32'hDEADBEEF, 1'b0, 1'b1}};
      vecs[5] = '{1'b1, 32'h104, 1'b1, 1'b1, 32'h304, 4'h3, 32'h0,        1'b0,
                  {1'b1, 1'b1, 32'h304, 4'h0, 32'h0,        1'b0, 1'b0}};
      vecs[6] = '{1'b1, 32'h108, 1'b1, 1'b0, 32'h20C, 4'h6, 32'h0000A5A5, 1'b1,
                  {1'b1, 1'b0, 32'h20C, 4'h6, 32'h0000A5A5, 1'b0, 1'b1}};

      do_reset();
      cyc_check();
      chk("reset_outs", 160'(dut_outs()), 160'(0));
      cyc_adv();

      for (int k = 0; k < 7; k++) begin
         do_reset();
         i_req = vecs[k].i_req; i_addr = vecs[k].i_addr;
         d_req = vecs[k].d_req; d_rnw = vecs[k].d_rnw; d_addr = vecs[k].d_addr;
         d_wmask = vecs[k].d_wmask; d_wdata = vecs[k].d_wdata; m_ack = vecs[k].m_ack;
         cyc_check();
         chk($sformatf("vec%0d", k),
             160'({m_bif_req, m_bif_rnw, m_bif_addr, m_bif_wmask, m_bif_wdata, i_bif_ack, d_bif_ack}),
             160'(vecs[k].exp));
         cyc_adv();
      end

      // simultaneous accept, then repeated ties to exercise the tie-break policy
      do_reset();
      i_req = 1'b1; i_addr = 32'h100; d_req = 1'b1; d_rnw = 1'b0; d_addr = 32'h200;
      d_wmask = 4'hF; d_wdata = 32'hDEADBEEF; m_ack = 1'b1;
      cyc_check(); chk("simul_c0", 160'({d_bif_ack, i_bif_ack, m_bif_addr}), 160'({1'b1, 1'b0, 32'h200})); cyc_adv();
      d_req = 1'b0;
      cyc_check(); chk("simul_c1", 160'({d_bif_ack, i_bif_ack, m_bif_addr}), 160'({1'b0, 1'b1, 32'h100})); cyc_adv();
      i_addr = 32'h104; d_req = 1'b1; d_addr = 32'h204; d_wdata = 32'h1;
      cyc_check(); chk("simul_tie2", 160'({d_bif_ack, i_bif_ack}), 160'({1'b1, 1'b0})); cyc_adv();
      d_addr = 32'h208; d_wdata = 32'h2;
      cyc_check(); chk("simul_tie3", 160'({d_bif_ack, i_bif_ack}), 160'({!RR, RR})); cyc_adv();
      idle(); drain();

      // grant stays locked on D while the bus stalls
      do_reset();
      d_req = 1'b1; d_rnw = 1'b1; d_addr = 32'h300; m_ack = 1'b0;
      cyc_check(); chk("stall_c0", 160'({m_bif_req, m_bif_addr}), 160'({1'b1, 32'h300})); cyc_adv();
      i_req = 1'b1; i_addr = 32'h180;
      for (int k = 1; k < 3; k++) begin
         cyc_check();
         chk("stall_hold", 160'({m_bif_addr, i_bif_ack, d_bif_ack}), 160'({32'h300, 1'b0, 1'b0}));
         cyc_adv();
      end
      m_ack = 1'b1;
      cyc_check(); chk("stall_ack_d", 160'({m_bif_addr, d_bif_ack, i_bif_ack}), 160'({32'h300, 1'b1, 1'b0})); cyc_adv();
      d_req = 1'b0;
      cyc_check(); chk("stall_ack_i", 160'({m_bif_addr, i_bif_ack}), 160'({32'h180, 1'b1})); cyc_adv();
      idle(); drain();

      // return routing for reads accepted as I, D, I
      do_reset();
      m_ack = 1'b1; i_req = 1'b1; i_addr = 32'h10; step();
      i_req = 1'b0; d_req = 1'b1; d_rnw = 1'b1; d_addr = 32'h20; step();
      d_req = 1'b0; i_req = 1'b1; i_addr = 32'h30; step();
      idle(); m_rvalid = 1'b1; m_rdata = 32'h11;
      cyc_check(); chk("route_1", 160'({i_bif_rvalid, d_bif_rvalid, i_bif_rdata}), 160'({1'b1, 1'b0, 32'h11})); cyc_adv();
      m_rdata = 32'h22;
      cyc_check(); chk("route_2", 160'({i_bif_rvalid, d_bif_rvalid, d_bif_rdata}), 160'({1'b0, 1'b1, 32'h22})); cyc_adv();
      m_rdata = 32'h33;
      cyc_check(); chk("route_3", 160'({i_bif_rvalid, d_bif_rvalid, i_bif_rdata}), 160'({1'b1, 1'b0, 32'h33})); cyc_adv();
      idle();

      // full FIFO: writes pass, reads wait until a return is seen
      do_reset();
      m_ack = 1'b1;
      for (int k = 0; k < 4; k++) begin
         i_req = 1'b1; i_addr = 32'h40 + 32'(4 * k); step();
      end
      idle(); m_ack = 1'b1;
      d_req = 1'b1; d_rnw = 1'b0; d_addr = 32'h500; d_wmask = 4'h3; d_wdata = 32'hCAFE0000;
      cyc_check(); chk("full_wr", 160'({d_bif_ack, m_bif_req, m_bif_rnw}), 160'({1'b1, 1'b1, 1'b0})); cyc_adv();
      d_rnw = 1'b1; d_addr = 32'h504; d_wmask = 4'h0; d_wdata = 32'h0;
      for (int k = 0; k < 2; k++) begin
         cyc_check(); chk("full_block", 160'({m_bif_req, d_bif_ack}), 160'({1'b0, 1'b0})); cyc_adv();
      end
      m_rvalid = 1'b1; m_rdata = 32'h77;
      cyc_check(); chk("full_pop_cyc", 160'({m_bif_req, d_bif_ack, i_bif_rvalid}), 160'({1'b0, 1'b0, 1'b1})); cyc_adv();
      m_rvalid = 1'b0;
      cyc_check(); chk("full_d_ack", 160'({m_bif_req, d_bif_ack, m_bif_addr}), 160'({1'b1, 1'b1, 32'h504})); cyc_adv();
      idle(); drain();

      // unexpected return with nothing outstanding
      do_reset();
      m_rvalid = 1'b1; m_rdata = 32'h55;
      cyc_check(); chk("unexp_rv", 160'({i_bif_rvalid, d_bif_rvalid, err_rvalid}), 160'({1'b0, 1'b0, 1'b0})); cyc_adv();
      m_rvalid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         cyc_check(); chk("unexp_err", 160'(err_rvalid), 160'(1)); cyc_adv();
      end

      // random traffic while the error flag is held
      rand_run(600);

      // reset with two reads outstanding and the lock set
      do_reset();
      m_ack = 1'b1; i_req = 1'b1; i_addr = 32'h60; step();
      i_req = 1'b0; d_req = 1'b1; d_rnw = 1'b1; d_addr = 32'h64; step();
      d_addr = 32'h68; m_ack = 1'b0; step();
      i_req = 1'b1; i_addr = 32'h6C;
      rstn = 1'b0;
      #1;
      chk("rst_mid_outs", 160'(dut_outs()), 160'(0));
      model_reset();
      step();
      idle(); rstn = 1'b1; m_rvalid = 1'b1; m_rdata = 32'h99;
      cyc_check(); chk("rst_mid_unexp", 160'({i_bif_rvalid, d_bif_rvalid, err_rvalid}), 160'({1'b0, 1'b0, 1'b0})); cyc_adv();
      m_rvalid = 1'b0;
      cyc_check(); chk("rst_mid_err", 160'(err_rvalid), 160'(1)); cyc_adv();

      // clean random traffic
      do_reset();
      rand_run(1500);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
